// File: rtl/clk_div_pkg.sv
// Shared defaults and helpers for the multi-channel clock divider.
package clk_div_pkg;

  localparam int CNT_W_DEF    = 26;
  localparam int DIV_INIT_DEF = 33_333_334;  // 3 Hz from 100 MHz

  // Rounded-up half of a divisor, widened by one bit so N = all-ones cannot wrap.
  function automatic logic [32:0] half_ceil(input logic [31:0] n);
    return ({1'b0, n} + 33'd1) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counter, applied/shadow divisor, pending flag and registered outputs.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DIV_INIT = DIV_INIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             we,
  input  logic [CNT_W-1:0] wdata,
  output logic             div_clk,
  output logic             tick,
  output logic             pend
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_act;
  logic [CNT_W-1:0] div_shd;
  logic [CNT_W-1:0] shd_eff;
  logic [CNT_W:0]   half;
  logic             halted;
  logic             boundary;

  assign halted   = (div_act == '0);
  assign boundary = en && !halted && (cnt == div_act - CNT_W'(1));
  // A write landing on the boundary or sync cycle is applied straight away.
  assign shd_eff  = we ? wdata : div_shd;
  assign half     = (CNT_W+1)'(half_ceil(32'(div_act)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      div_act <= CNT_W'(DIV_INIT);
      div_shd <= CNT_W'(DIV_INIT);
      pend    <= 1'b0;
      div_clk <= 1'b0;
      tick    <= 1'b0;
    end else begin
      tick <= boundary;
      if (halted) begin
        div_clk <= 1'b0;
      end else if (en) begin
        div_clk <= ({1'b0, cnt} < half);
      end

      if (we) begin
        div_shd <= wdata;
      end

      if (sync || boundary) begin
        cnt     <= '0;
        div_act <= shd_eff;
        pend    <= 1'b0;
      end else if (halted) begin
        // A halted channel never reaches a boundary, so wake it from the shadow.
        cnt  <= '0;
        pend <= we;
        if (pend) begin
          div_act <= div_shd;
        end
      end else begin
        if (en) begin
          cnt <= cnt + CNT_W'(1);
        end
        if (we) begin
          pend <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: decodes divisor writes and fans out sync.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter  int NUM_CH   = 2,
  parameter  int CNT_W    = CNT_W_DEF,
  parameter  int DIV_INIT = DIV_INIT_DEF,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_100MHz,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] clk_o,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] pend_o
);

  logic [NUM_CH-1:0] ch_we;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      // Addresses at or beyond NUM_CH match no channel and are dropped.
      assign ch_we[gi] = cfg_we && (cfg_ch == CH_W'(gi));

      clk_div_ch #(
        .CNT_W    (CNT_W),
        .DIV_INIT (DIV_INIT)
      ) u_ch (
        .clk     (clk_100MHz),
        .rst     (rst),
        .en      (en[gi]),
        .sync    (sync),
        .we      (ch_we[gi]),
        .wdata   (cfg_div),
        .div_clk (clk_o[gi]),
        .tick    (tick_o[gi]),
        .pend    (pend_o[gi])
      );
    end
  endgenerate

endmodule
